// File: rtl/fma_pkg.sv
// Shared FMA types: the multiplier request/response structs used between the
// FMA cores and the shared multiplier service, plus its fixed pipeline depth.
package fma_pkg;

  localparam int MUL_AW      = 27;
  localparam int MUL_PW      = 2 * MUL_AW;
  localparam int MUL_SRV_LAT = 3;

  // Request issued by an FMA core's mul port.
  typedef struct packed {
    logic              en;
    logic [MUL_AW-1:0] req_in_1;
    logic [MUL_AW-1:0] req_in_2;
  } mulit;

  // Product returned to an FMA core's mul port.
  typedef struct packed {
    logic [MUL_PW-1:0] out;
  } mulot;

  // Requester identity carried down the pipeline as the result tag.
  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

endpackage

// File: rtl/mul_srv_arb.sv
// Two-way request arbiter for the shared multiplier.
// MUL_SRV_RR_EN defined  : round-robin with a preference pointer.
// MUL_SRV_RR_EN undefined: fixed priority, port 0 always wins.
// Grants are combinational and forced low while reset is asserted.
module mul_srv_arb
  import fma_pkg::*;
(
`ifdef MUL_SRV_RR_EN
  input  logic clk,
`endif
  input  logic reset,
  input  logic en0,
  input  logic en1,
  output logic rdy0,
  output logic rdy1
);

`ifdef MUL_SRV_RR_EN
  port_e r_ptr;

  // Preference pointer: after a grant, prefer the port that was not served.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ptr <= PORT0;
    end else if (rdy0) begin
      r_ptr <= PORT1;
    end else if (rdy1) begin
      r_ptr <= PORT0;
    end
  end

  // Grant: a lone requester wins; under contention the preferred port wins.
  // NOTE: both outputs get a default first so no path leaves them unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    if (reset) begin
      if (en0 && en1) begin
        rdy0 = (r_ptr == PORT0);
        rdy1 = (r_ptr == PORT1);
      end else begin
        rdy0 = en0;
        rdy1 = en1;
      end
    end
  end
`else
  // Grant: port 0 has absolute priority; port 1 only when port 0 is idle.
  always_comb begin
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    if (reset) begin
      rdy0 = en0;
      rdy1 = en1 && !en0;
    end
  end
`endif

endmodule

// File: rtl/mul_srv.sv
// Shared pipelined multiplier responder for two FMA mul ports.
// One request accepted per cycle, 3 register stages (operands, partial
// products, summed product), result steered back to the issuing port by tag.
// Arbitration policy selected by MUL_SRV_RR_EN (see mul_srv_arb).
module mul_srv
  import fma_pkg::*;
#(
  parameter int AW = MUL_AW
) (
  input  logic clk,
  input  logic reset,
  input  mulit muli0,
  input  mulit muli1,
  output logic rdy0,
  output logic rdy1,
  output mulot mulo0,
  output mulot mulo1,
  output logic vld0,
  output logic vld1,
  output logic busy
);

  // Multiplier b operand is split into a low and a high slice so each stage
  // carries a narrower multiply; the split point puts 14 bits low for AW=27.
  localparam int LO_W  = (AW + 1) / 2;
  localparam int HI_W  = AW - LO_W;
  localparam int PP0_W = AW + LO_W;
  localparam int PP1_W = AW + HI_W;
  localparam int PW    = 2 * AW;

  logic          w_acc;
  port_e         w_tag;
  logic [AW-1:0] w_a;
  logic [AW-1:0] w_b;
  logic [PW-1:0] w_prod;

  logic          r_s1_vld;
  port_e         r_s1_tag;
  logic [AW-1:0] r_s1_a;
  logic [AW-1:0] r_s1_b;

  logic          r_s2_vld;
  port_e         r_s2_tag;
  logic [PP0_W-1:0] r_pp0;
  logic [PP1_W-1:0] r_pp1;

  logic          r_vld0;
  logic          r_vld1;
  logic [PW-1:0] r_out0;
  logic [PW-1:0] r_out1;

  mul_srv_arb u_arb (
`ifdef MUL_SRV_RR_EN
    .clk   (clk),
`endif
    .reset (reset),
    .en0   (muli0.en),
    .en1   (muli1.en),
    .rdy0  (rdy0),
    .rdy1  (rdy1)
  );

  // Issue select: the arbiter grants at most one port, so its rdy picks the
  // operands and the tag.
  assign w_acc  = rdy0 | rdy1;
  assign w_tag  = rdy1 ? PORT1 : PORT0;
  assign w_a    = rdy1 ? muli1.req_in_1 : muli0.req_in_1;
  assign w_b    = rdy1 ? muli1.req_in_2 : muli0.req_in_2;

  // Recombine partial products; exact in PW bits.
  assign w_prod = PW'(r_pp0) + (PW'(r_pp1) << LO_W);

  // Control path: stage valids, result strobes and held outputs. Reset
  // discards in-flight work so no strobe fires for it afterwards.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
      r_vld0   <= 1'b0;
      r_vld1   <= 1'b0;
      r_out0   <= '0;
      r_out1   <= '0;
    end else begin
      r_s1_vld <= w_acc;
      r_s2_vld <= r_s1_vld;
      r_vld0   <= r_s2_vld && (r_s2_tag == PORT0);
      r_vld1   <= r_s2_vld && (r_s2_tag == PORT1);
      if (r_s2_vld && (r_s2_tag == PORT0)) r_out0 <= w_prod;
      if (r_s2_vld && (r_s2_tag == PORT1)) r_out1 <= w_prod;
    end
  end

  // Datapath: operand capture and partial-product multiply.
  // NOTE: these registers are qualified by the valid bits above, so they need
  // no reset; leaving it off keeps the reset net away from the wide datapath.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_s1_a   <= w_a;
      r_s1_b   <= w_b;
      r_s1_tag <= w_tag;
    end
    r_pp0    <= PP0_W'(r_s1_a) * PP0_W'(r_s1_b[LO_W-1:0]);
    r_pp1    <= PP1_W'(r_s1_a) * PP1_W'(r_s1_b[AW-1:LO_W]);
    r_s2_tag <= r_s1_tag;
  end

  assign mulo0.out = r_out0;
  assign mulo1.out = r_out1;
  assign vld0      = r_vld0;
  assign vld1      = r_vld1;
  assign busy      = r_s1_vld | r_s2_vld | r_vld0 | r_vld1;

endmodule
